// File: rtl/store_buffer_if.sv
// Commit-side push channel and store-unit issue channel of the store buffer.
// STORE_BUF_FWD_EN adds the load-forwarding lookup signals.
interface store_buffer_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              push_valid;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic              push_ready;
    logic              st_busy;
    logic              st_set_busy;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
`ifdef STORE_BUF_FWD_EN
    logic [ADDR_W-1:0] ld_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
`endif

    // Buffer side
    modport slave (
        input  push_valid, push_addr, push_data, st_busy,
`ifdef STORE_BUF_FWD_EN
        input  ld_addr,
        output fwd_hit, fwd_data,
`endif
        output push_ready, st_set_busy, st_addr, st_data, count, empty
    );

    // Commit stage / store unit side
    modport master (
        output push_valid, push_addr, push_data, st_busy,
`ifdef STORE_BUF_FWD_EN
        output ld_addr,
        input  fwd_hit, fwd_data,
`endif
        input  push_ready, st_set_busy, st_addr, st_data, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// In-order FIFO of committed stores issued one at a time to the store unit.
// Optional load forwarding is enabled with `define STORE_BUF_FWD_EN.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_push_ready;
    logic              r_empty;
    logic              r_set_busy;
    logic [ADDR_W-1:0] r_st_addr;
    logic [DATA_W-1:0] r_st_data;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_nxt;

    // The !r_set_busy term covers the cycle before the store unit raises busy
    always_comb begin
        w_push      = bus.push_valid && r_push_ready;
        w_pop       = (r_count != '0) && !bus.st_busy && !r_set_busy;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Pointers, occupancy flags and the registered issue port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_push_ready <= 1'b1;
            r_empty      <= 1'b1;
            r_set_busy   <= 1'b0;
            r_st_addr    <= '0;
            r_st_data    <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head    <= r_head + PTR_W'(1);
                r_st_addr <= r_addr_mem[r_head];
                r_st_data <= r_data_mem[r_head];
            end
            r_set_busy   <= w_pop;
            r_count      <= w_count_nxt;
            r_push_ready <= (w_count_nxt != CNT_W'(DEPTH));
            r_empty      <= (w_count_nxt == '0);
        end
    end

    // Entry storage carries no reset; validity comes from the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= bus.push_addr;
            r_data_mem[r_tail] <= bus.push_data;
        end
    end

    assign bus.push_ready  = r_push_ready;
    assign bus.empty       = r_empty;
    assign bus.count       = r_count;
    assign bus.st_set_busy = r_set_busy;
    assign bus.st_addr     = r_st_addr;
    assign bus.st_data     = r_st_data;

`ifdef STORE_BUF_FWD_EN
    // Walk oldest to youngest so the last match wins
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (CNT_W'(k) < r_count) begin
                if (r_addr_mem[r_head + PTR_W'(k)] == bus.ld_addr) begin
                    bus.fwd_hit  = 1'b1;
                    bus.fwd_data = r_data_mem[r_head + PTR_W'(k)];
                end
            end
        end
    end
`endif

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- FIFO of committed stores that sits directly upstream of the store unit.
- Accepts address/data pairs from the commit stage through a valid/ready handshake.
- Issues them in program order to the store unit using its set_busy/busy protocol, one store in flight at a time.
- Decouples commit from memory-side stalls.

Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- ADDR_W, 32: store address width.
- DATA_W, 32: store data width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- push_valid  input  1  commit stage presents a store
- push_addr  input  ADDR_W  store address
- push_data  input  DATA_W  store data
- push_ready  output  1  buffer can accept; equals (count != DEPTH)
- st_busy  input  1  busy output of the store unit
- st_set_busy  output  1  issue strobe to the store unit's set_busy
- st_addr  output  ADDR_W  issued address, to store_addr
- st_data  output  DATA_W  issued data, to store_data
- count  output  $clog2(DEPTH+1)  occupied entries
- empty  output  1  count == 0

Interface rule: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values:
  - count = 0, head = tail = 0, empty = 1, push_ready = 1.
  - st_set_busy = 0, st_addr = 0, st_data = 0.
  - Entry storage is not reset.
- Push:
  - Occurs at a rising edge when push_valid && push_ready.
  - Writes the entry at tail; tail advances modulo DEPTH.
  - Data written in a cycle is not eligible to issue in that same cycle.
  - A push while full is ignored; commit must hold push_valid.
- Issue condition, evaluated at each edge: count != 0 && !st_busy && !st_set_busy.
  - When true:
    - st_set_busy <= 1.
    - st_addr/st_data <= entry[head].
    - head advances modulo DEPTH (pop).
  - Otherwise st_set_busy <= 0.
  - st_addr/st_data hold their last issued values.
- Pulse width:
  - st_set_busy is a registered single-cycle pulse.
  - It never stays high two consecutive cycles.
  - The !st_set_busy term covers the one-cycle gap before the store unit raises busy.
- Timing:
  - Issue edge E0 → st_set_busy high in cycle E0..E1.
  - Store unit busy high E1..E2; next issue edge E3.
  - Back-to-back stores therefore issue every 3 cycles while st_busy drops after one cycle.
  - If st_busy stays high, issue stalls until it falls.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop at the same edge: unchanged; head and tail both advance.
- Full boundary:
  - push_ready is derived from the current count, not the post-pop count.
  - A push is refused while full even in a popping cycle.
- Wrap-around:
  - Pointers are ADDR_PTR = log2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by count only.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - Pending entries are discarded.
  - An in-progress st_set_busy pulse is cut.
- Ordering: strict FIFO; no merging or coalescing of same-address stores.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined: adds ports ld_addr (input, ADDR_W), fwd_hit (output, 1) and fwd_data (output, DATA_W).
  - Combinational lookup over the valid entries.
  - fwd_hit = 1 when any entry's address equals ld_addr.
  - fwd_data = data of the youngest matching entry, closest to tail.
  - With no match, fwd_hit = 0 and fwd_data = 0.
  - An entry popped at the current edge is no longer searched in the following cycle.
- Undefined: these ports and the compare logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-run with 3 entries → count=0, empty=1, push_ready=1, st_set_busy=0 on the same cycle; no issue after release.
- Order/spacing:
  - Stimulus: push (0x100,0xA), (0x104,0xB), (0x108,0xC) on consecutive cycles; model store unit with 1-cycle busy.
  - Response: st_set_busy pulses carry A, B, C in order, 3 cycles apart; count ends 0.
- Full: DEPTH=4, st_busy held 1, 5 pushes → push_ready=0 after 4th; 5th is held and accepted only after the first issue frees an entry.
- Simultaneous: count=2, push and issue on the same edge → count stays 2; the pushed entry issues third.
- Stall/wrap: 10 stores through DEPTH=4 with random 1–4 cycle busy → every data value appears exactly once, in order, and st_set_busy is never high while st_busy=1.
- Forwarding (STORE_BUF_FWD_EN): entries (0x200,0x1), (0x200,0x2) and ld_addr=0x200 → fwd_hit=1, fwd_data=0x2; ld_addr=0x300 → fwd_hit=0.
